// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared encodings and widths for the RV32M divider
package div_unit_pkg;
   localparam int DATA_W = 32;
   localparam int CNT_W  = $clog2(DATA_W);

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/div_unit_iter.sv
// rtl/div_unit_iter.sv - unsigned restoring shift-subtract core, one quotient bit per step
module udiv_iter #(
   parameter int n = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         step,
   input  logic [n-1:0] dividend,
   input  logic [n-1:0] divisor,
   output logic [n-1:0] quotient,
   output logic [n-1:0] remainder
);
   logic [n-1:0] q_r;
   logic [n-1:0] d_r;
   logic [n:0]   r_r;
   logic [n+1:0] shifted;
   logic [n+1:0] diff;

   // Dividend bits shift out of q_r as quotient bits shift in; diff[n+1] is the borrow.
   always_comb begin
      shifted = {r_r, q_r[n-1]};
      diff    = shifted - {2'b00, d_r};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_r <= '0;
         d_r <= '0;
         r_r <= '0;
      end else if (load) begin
         q_r <= dividend;
         d_r <= divisor;
         r_r <= '0;
      end else if (step) begin
         if (diff[n+1]) begin
            r_r <= shifted[n:0];
            q_r <= {q_r[n-2:0], 1'b0};
         end else begin
            r_r <= diff[n:0];
            q_r <= {q_r[n-2:0], 1'b1};
         end
      end
   end

   assign quotient  = q_r;
   assign remainder = r_r[n-1:0];
endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle DIV/DIVU/REM/REMU execute unit with flush support
module div_unit
   import div_unit_pkg::*;
#(
   parameter int n = DATA_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         kill,
   input  logic [1:0]   op,
   input  logic [n-1:0] rs1_val,
   input  logic [n-1:0] rs2_val,
   input  logic [4:0]   rd_in,
   output logic         busy,
   output logic         done,
   output logic         wr_en,
   output logic [n-1:0] result,
   output logic [4:0]   rd_out
);
   state_t             state_q, state_d;
   logic               rem_sel_q, q_neg_q, r_neg_q;
   logic [4:0]         rd_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [n-1:0]       result_q;
   logic [4:0]         rd_out_q;

   logic               is_signed, a_neg, b_neg, div_zero, ovf, special, accept;
   logic               load, step;
   logic [n-1:0]       a_mag, b_mag, special_res, quo, rem, q_fix, r_fix, fix_res;

   always_comb begin
      is_signed = ~op[0];
      a_neg     = is_signed & rs1_val[n-1];
      b_neg     = is_signed & rs2_val[n-1];
      a_mag     = a_neg ? -rs1_val : rs1_val;
      b_mag     = b_neg ? -rs2_val : rs2_val;
      div_zero  = (rs2_val == '0);
      ovf       = is_signed && (rs1_val == {1'b1, {(n-1){1'b0}}}) && (rs2_val == '1);
      special   = div_zero | ovf;
      accept    = start && !kill && (state_q == IDLE || state_q == DONE);
      // Divide-by-zero and signed overflow resolve without iterating.
      if (div_zero) special_res = op[1] ? rs1_val : '1;
      else          special_res = op[1] ? '0 : rs1_val;
      q_fix     = q_neg_q ? -quo : quo;
      r_fix     = r_neg_q ? -rem : rem;
      fix_res   = rem_sel_q ? r_fix : q_fix;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept) begin
               if (special) begin
                  state_d = DONE;
               end else begin
                  state_d = CALC;
                  load    = 1'b1;
               end
            end
         end
         CALC: begin
            if (kill) begin
               state_d = IDLE;
            end else begin
               step = 1'b1;
               if (cnt_q == CNT_W'(n - 1)) state_d = FIX;
            end
         end
         FIX:     state_d = kill ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_sel_q <= 1'b0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         rd_q      <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         rd_out_q  <= '0;
      end else begin
         if (accept) begin
            rem_sel_q <= op[1];
            q_neg_q   <= a_neg ^ b_neg;
            r_neg_q   <= a_neg;
            rd_q      <= rd_in;
            cnt_q     <= '0;
            if (special) begin
               result_q <= special_res;
               rd_out_q <= rd_in;
            end
         end
         if (state_q == CALC && !kill) cnt_q <= cnt_q + 1'b1;
         if (state_q == FIX && !kill) begin
            result_q <= fix_res;
            rd_out_q <= rd_q;
         end
      end
   end

   udiv_iter #(.n(n)) u_iter (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .step      (step),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .quotient  (quo),
      .remainder (rem)
   );

   assign busy   = (state_q == CALC) || (state_q == FIX);
   assign done   = (state_q == DONE);
   assign wr_en  = done;
   assign result = result_q;
   assign rd_out = rd_out_q;
endmodule
